// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and its input loader: opcode constants,
// the loader FSM state encoding and the opcode legality check.
package alu_pkg;

  localparam int OP_BITS = 6;

  localparam logic [OP_BITS-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_BITS-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_BITS-1:0] OP_AND = 6'b100100;
  localparam logic [OP_BITS-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_BITS-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_BITS-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_BITS-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_BITS-1:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } loader_state_t;

  function automatic logic is_legal_op(input logic [OP_BITS-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and operand/opcode outputs of the ALU input loader.
// The loader uses the slave view; whatever drives the switches and buttons uses master.
interface alu_input_loader_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0]          sw;
  logic                       btn_a;
  logic                       btn_b;
  logic                       btn_op;
  logic [N_BITS-1:0]          d0;
  logic [N_BITS-1:0]          d1;
  logic [alu_pkg::OP_BITS-1:0] opcode;
  logic                       valid;
  logic                       op_err;
  logic [1:0]                 state;

  modport slave (
    input  sw, btn_a, btn_b, btn_op,
    output d0, d1, opcode, valid, op_err, state
  );

  modport master (
    output sw, btn_a, btn_b, btn_op,
    input  d0, d1, opcode, valid, op_err, state
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counting debouncer and single-cycle rising-edge pulse
// for one raw push-button.
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // Until the button has been seen stably low after reset, a high level cannot
  // count as a press; r_armed records that the low level was confirmed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_pulse <= 1'b0;
      if (!r_armed) begin
        if (r_sync1) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_armed <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync1;
        r_pulse <= r_sync1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/alu_input_loader.sv
// Loads two ALU operands and an opcode from a switch bank, one debounced
// button per register, sequenced by a four-state FSM.
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_input_loader_if.slave bus
);

  logic w_pulse_a;
  logic w_pulse_b;
  logic w_pulse_op;
  logic w_sel_a;
  logic w_sel_b;
  logic w_sel_op;
  logic [OP_BITS-1:0] w_op;
  logic w_op_legal;

  logic [N_BITS-1:0]  r_d0;
  logic [N_BITS-1:0]  r_d1;
  logic [OP_BITS-1:0] r_opcode;
  logic               r_valid;
  logic               r_op_err;
  loader_state_t      r_state;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk(clk), .reset(reset), .i_btn(bus.btn_a), .o_pulse(w_pulse_a)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk(clk), .reset(reset), .i_btn(bus.btn_b), .o_pulse(w_pulse_b)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_op (
    .clk(clk), .reset(reset), .i_btn(bus.btn_op), .o_pulse(w_pulse_op)
  );

  // One press per cycle at most; lower-priority coincident presses are dropped.
  assign w_sel_a    = w_pulse_a;
  assign w_sel_b    = w_pulse_b & ~w_pulse_a;
  assign w_sel_op   = w_pulse_op & ~w_pulse_a & ~w_pulse_b;
  assign w_op       = bus.sw[OP_BITS-1:0];
  assign w_op_legal = is_legal_op(w_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d0     <= '0;
      r_d1     <= '0;
      r_opcode <= '0;
      r_valid  <= 1'b0;
      r_op_err <= 1'b0;
      r_state  <= WAIT_A;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (w_sel_a) begin
            r_d0    <= bus.sw;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_sel_b) begin
            r_d1    <= bus.sw;
            r_state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (w_sel_op) begin
            if (w_op_legal) begin
              r_opcode <= w_op;
              r_op_err <= 1'b0;
              r_valid  <= 1'b1;
              r_state  <= READY;
            end else begin
              r_op_err <= 1'b1;
            end
          end
        end
        READY: begin
          if (w_sel_a) begin
            r_d0    <= bus.sw;
            r_valid <= 1'b0;
            r_state <= WAIT_B;
          end else if (w_sel_b) begin
            r_d1 <= bus.sw;
          end else if (w_sel_op) begin
            if (w_op_legal) begin
              r_opcode <= w_op;
              r_op_err <= 1'b0;
            end else begin
              r_op_err <= 1'b1;
            end
          end
        end
        default: r_state <= WAIT_A;
      endcase
    end
  end

  assign bus.d0     = r_d0;
  assign bus.d1     = r_d1;
  assign bus.opcode = r_opcode;
  assign bus.valid  = r_valid;
  assign bus.op_err = r_op_err;
  assign bus.state  = r_state;

endmodule
